// File: rtl/ahb_lite_master_port_if.sv
// ahb_lite_master_port_if: command/response handshake plus AHB-Lite master bus signals
interface ahb_lite_master_port_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
    );
endinterface

// File: rtl/ahb_lite_master_port.sv
// ahb_lite_master_port: turns a command/response stream into pipelined AHB-Lite single word transfers
module ahb_lite_master_port #(
    parameter logic [3:0] P_HPROT = 4'b0011
) (
    input logic HCLK,
    input logic HRESET,
    ahb_lite_master_port_if.master bus
);
    logic        a_valid;
    logic [31:0] a_wdata;
    logic        d_valid;
    logic        d_write;
    logic        err_hold;
    logic        cancel_pending;
    logic        accept;
    logic        a_done;
    logic        d_done;
    logic        err_first;
    logic        cancel_done;
    assign bus.cmd_ready = !HRESET && !err_hold && !cancel_pending && (!a_valid || bus.HREADY);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign a_done        = a_valid && bus.HREADY;
    assign d_done        = d_valid && bus.HREADY;
    assign err_first     = d_valid && bus.HRESP && !bus.HREADY;
    // the cancelled command retires once the erroring transfer has left the data slot
    assign cancel_done   = cancel_pending && !d_valid;
    assign bus.HTRANS    = a_valid ? 2'b10 : 2'b00;
    assign bus.HSIZE     = 3'b010;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = P_HPROT;
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_valid        <= 1'b0;
            a_wdata        <= '0;
            d_valid        <= 1'b0;
            d_write        <= 1'b0;
            err_hold       <= 1'b0;
            cancel_pending <= 1'b0;
            bus.HADDR      <= '0;
            bus.HWRITE     <= 1'b0;
            bus.HWDATA     <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_rdata  <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                a_valid    <= 1'b1;
                bus.HADDR  <= bus.cmd_addr;
                bus.HWRITE <= bus.cmd_write;
                a_wdata    <= bus.cmd_wdata;
            end else if (a_done || err_first) begin
                a_valid <= 1'b0;
            end
            if (a_done) begin
                d_valid <= 1'b1;
                d_write <= bus.HWRITE;
            end else if (d_done) begin
                d_valid <= 1'b0;
            end
            if (a_done && bus.HWRITE) bus.HWDATA <= a_wdata;
            // first ERROR cycle: stop issuing and drop the queued address phase
            if (err_first) begin
                err_hold <= 1'b1;
                if (a_valid) cancel_pending <= 1'b1;
            end else if (cancel_done) begin
                err_hold       <= 1'b0;
                cancel_pending <= 1'b0;
            end else if (d_done && !cancel_pending) begin
                err_hold <= 1'b0;
            end
            bus.rsp_valid <= d_done || cancel_done;
            bus.rsp_err   <= d_done ? bus.HRESP : cancel_done;
            bus.rsp_rdata <= (d_done && !d_write && !bus.HRESP) ? bus.HRDATA : 32'h0;
        end
    end
endmodule

// File: tb/tb_ahb_lite_master_port.sv
// tb_ahb_lite_master_port: scoreboard bench with hand-timed corner sequences and a table run against a slave model
module tb_ahb_lite_master_port;
    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    ahb_lite_master_port_if bus();
    ahb_lite_master_port #(.P_HPROT(4'b0011)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    rsp_t sb[$];
    rsp_t cur_exp;
    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;
    logic last_acc;

    logic        slave_auto = 1'b0;
    logic        m_ready = 1'b1;
    logic        m_resp = 1'b0;
    logic [31:0] m_rdata = 32'h0;

    // slave model: word memory at addr[5:2], addr[7:6] wait states, addr[8] answers ERROR
    logic [31:0] mem [16] = '{default: 32'h0};
    logic        dp_valid = 1'b0;
    logic        dp_write = 1'b0;
    logic        err2 = 1'b0;
    logic [31:0] dp_addr = 32'h0;
    logic [1:0]  cnt = 2'd0;
    wire         is_err = dp_addr[8];
    wire         a_ready = !dp_valid || (cnt == 2'd0 && (!is_err || err2));
    wire         a_resp = dp_valid && cnt == 2'd0 && is_err;
    assign bus.HREADY = slave_auto ? a_ready : m_ready;
    assign bus.HRESP  = slave_auto ? a_resp : m_resp;
    assign bus.HRDATA = slave_auto ? mem[dp_addr[5:2]] : m_rdata;

    always @(posedge HCLK) begin
        if (bus.HREADY) begin
            if (slave_auto && dp_valid && dp_write && !is_err) mem[dp_addr[5:2]] <= bus.HWDATA;
            dp_valid <= slave_auto && bus.HTRANS == 2'b10;
            dp_addr  <= bus.HADDR;
            dp_write <= bus.HWRITE;
            cnt      <= bus.HADDR[7:6];
            err2     <= 1'b0;
        end else if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
        end else if (is_err) begin
            err2 <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic err);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        cur_exp.rdata = rdata;
        cur_exp.err   = err;
    endtask

    task automatic tick();
        rsp_t e;
        #2;
        last_acc = bus.cmd_valid && bus.cmd_ready;
        @(posedge HCLK);
        #1;
        if (last_acc) sb.push_back(cur_exp);
        if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious rsp: got rsp_valid=1 expected no outstanding command");
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
            end
        end
        chk("htrans_kind", {31'h0, bus.HTRANS[0]}, 32'h0);
        if (bus.HTRANS == 2'b10) begin
            chk("hsize", {29'h0, bus.HSIZE}, 32'h2);
            chk("hburst", {29'h0, bus.HBURST}, 32'h0);
            chk("hprot", {28'h0, bus.HPROT}, 32'h3);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h000, 32'h11111111, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 32'h044, 32'h22222222, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 32'h000, 32'h0, 32'h11111111, 1'b0};
        vecs[3]  = '{1'b0, 32'h0C4, 32'h0, 32'h22222222, 1'b0};
        vecs[4]  = '{1'b1, 32'h108, 32'h33, 32'h0, 1'b1};
        vecs[5]  = '{1'b1, 32'h008, 32'h44, 32'h0, 1'b1};
        vecs[6]  = '{1'b0, 32'h008, 32'h0, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 32'h08C, 32'h55667788, 32'h0, 1'b0};
        vecs[8]  = '{1'b0, 32'h00C, 32'h0, 32'h55667788, 1'b0};
        vecs[9]  = '{1'b0, 32'h148, 32'h0, 32'h0, 1'b1};
        vecs[10] = '{1'b0, 32'h004, 32'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b0, 32'h044, 32'h0, 32'h22222222, 1'b0};
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        cur_exp = '{32'h0, 1'b0};

        tick();
        tick();
        chk("rst_htrans", {30'h0, bus.HTRANS}, 32'h0);
        chk("rst_haddr", bus.HADDR, 32'h0);
        chk("rst_hwrite", {31'h0, bus.HWRITE}, 32'h0);
        chk("rst_hwdata", bus.HWDATA, 32'h0);
        chk("rst_rsp", {bus.rsp_rdata[30:0], bus.rsp_valid}, 32'h0);
        bus.cmd_valid = 1'b1;
        #1;
        chk("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
        bus.cmd_valid = 1'b0;
        HRESET = 1'b0;
        tick();

        // single GPIO write: address c+1, data c+2, response c+3
        cmd(1'b1, 32'h4, 32'h1, 32'h0, 1'b0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("w_htrans", {30'h0, bus.HTRANS}, 32'h2);
        chk("w_haddr", bus.HADDR, 32'h4);
        chk("w_hwrite", {31'h0, bus.HWRITE}, 32'h1);
        tick();
        chk("w_hwdata", bus.HWDATA, 32'h1);
        chk("w_idle", {30'h0, bus.HTRANS}, 32'h0);
        tick();
        chk("w_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
        tick();
        chk("w_rsp_pulse", {31'h0, bus.rsp_valid}, 32'h0);

        // back-to-back write then read
        m_rdata = 32'h0000A5A5;
        cmd(1'b1, 32'h0, 32'h0000A5A5, 32'h0, 1'b0);
        tick();
        chk("b2b_w_htrans", {30'h0, bus.HTRANS}, 32'h2);
        cmd(1'b0, 32'h0, 32'h0, 32'h0000A5A5, 1'b0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("b2b_r_htrans", {30'h0, bus.HTRANS}, 32'h2);
        chk("b2b_r_hwrite", {31'h0, bus.HWRITE}, 32'h0);
        chk("b2b_hwdata", bus.HWDATA, 32'h0000A5A5);
        tick();
        chk("b2b_rsp1", {31'h0, bus.rsp_valid}, 32'h1);
        tick();
        chk("b2b_rsp2", {31'h0, bus.rsp_valid}, 32'h1);

        // three wait states on a read with a write queued behind it
        m_rdata = 32'h00001234;
        cmd(1'b0, 32'h0, 32'h0, 32'h00001234, 1'b0);
        tick();
        cmd(1'b1, 32'h20, 32'h77, 32'h0, 1'b0);
        tick();
        bus.cmd_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("ws_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
            chk("ws_htrans", {30'h0, bus.HTRANS}, 32'h2);
            chk("ws_haddr", bus.HADDR, 32'h20);
            chk("ws_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
            tick();
        end
        m_ready = 1'b1;
        chk("ws_no_rsp_c5", {31'h0, bus.rsp_valid}, 32'h0);
        tick();
        chk("ws_rsp_c6", {31'h0, bus.rsp_valid}, 32'h1);
        chk("ws_hwdata", bus.HWDATA, 32'h77);
        tick();
        chk("ws_rsp_w", {31'h0, bus.rsp_valid}, 32'h1);

        // ERROR on a write with a read pipelined behind it
        m_rdata = 32'h00000BAD;
        cmd(1'b1, 32'h8, 32'h55, 32'h0, 1'b1);
        tick();
        cmd(1'b0, 32'hC, 32'h0, 32'h0, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
        m_ready = 1'b0;
        m_resp = 1'b1;
        #1;
        chk("err1_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
        chk("err1_haddr", bus.HADDR, 32'hC);
        tick();
        m_ready = 1'b1;
        #1;
        chk("err2_htrans", {30'h0, bus.HTRANS}, 32'h0);
        chk("err2_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
        tick();
        m_resp = 1'b0;
        #1;
        chk("err_rsp1", {31'h0, bus.rsp_valid}, 32'h1);
        chk("err_htrans_c4", {30'h0, bus.HTRANS}, 32'h0);
        chk("err_cmd_ready_c4", {31'h0, bus.cmd_ready}, 32'h0);
        tick();
        chk("err_rsp2", {31'h0, bus.rsp_valid}, 32'h1);
        chk("err_htrans_c5", {30'h0, bus.HTRANS}, 32'h0);
        chk("err_cmd_ready_back", {31'h0, bus.cmd_ready}, 32'h1);
        tick();

        // HRESP without a preceding ERROR cycle still retires with an error
        cmd(1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        m_resp = 1'b1;
        tick();
        m_resp = 1'b0;
        #1;
        chk("viol_rsp", {31'h0, bus.rsp_valid}, 32'h1);
        chk("viol_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);

        // reset during the data phase of a read
        cmd(1'b0, 32'h30, 32'h0, 32'h99, 1'b0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        HRESET = 1'b1;
        m_ready = 1'b0;
        tick();
        sb.delete();
        m_ready = 1'b1;
        #1;
        chk("mr_htrans", {30'h0, bus.HTRANS}, 32'h0);
        chk("mr_haddr", bus.HADDR, 32'h0);
        chk("mr_rsp", {31'h0, bus.rsp_valid}, 32'h0);
        chk("mr_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
        HRESET = 1'b0;
        #1;
        chk("mr_cmd_ready_rel", {31'h0, bus.cmd_ready}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mr_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
        end

        // table run against the slave model, issuing as fast as cmd_ready allows
        slave_auto = 1'b1;
        begin
            int i;
            int cyc;
            i = 0;
            cyc = 0;
            while ((i < 12 || sb.size() != 0) && cyc < 400) begin
                if (i < 12) cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
                else bus.cmd_valid = 1'b0;
                tick();
                if (last_acc) i++;
                cyc++;
            end
            bus.cmd_valid = 1'b0;
            chk("table_issued", i, 12);
        end
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
